// File: rtl/audio_codec_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// audio_codec_cfg_sequencer
//
// Walks the fixed 11-entry WM8731 register table and hands one 24-bit word at
// a time to the I2C serial programmer. Each word is presented as
// {DEV_ADDR, reg[6:0], data[8:0]}. The transfer is opened with mgo and ends
// when the programmer's mend flag is seen low and then high again. A NACK
// (mack=1) or a stuck transfer is retried until RETRY_MAX attempts have failed.
//
// Ports:
//   clk         I2C control clock, shared with the programmer
//   reset       asynchronous, active-high
//   start       single-cycle request to (re)run the sequence (ignored while busy)
//   mend        programmer transfer-end flag (0 = armed/running, 1 = finished)
//   mack        programmer ack flag (1 = NACK seen), valid while mend=1
//   mgo         transfer enable to the programmer
//   mstep       current table index
//   i2c_data    word being transmitted
//   busy        sequence in progress
//   done        every word acknowledged
//   error       a word exhausted its retries
//   nack_total  saturating count of failed attempts in the current run
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module audio_codec_cfg_sequencer #(
    parameter logic [7:0] DEV_ADDR      = 8'h34,
    parameter int         RETRY_MAX     = 3,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         WAIT_TIMEOUT  = 255,
    parameter int         AUTO_START    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mend,
    input  logic        mack,
    output logic        mgo,
    output logic [3:0]  mstep,
    output logic [23:0] i2c_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  nack_total
);

    localparam logic [3:0] LAST_IDX = 4'd10;
    // One counter serves LOAD length, SETTLE length and the GO timeout; it is
    // cleared on every state change, so it must hold the largest of them.
    localparam int CNT_MAX = (WAIT_TIMEOUT > SETTLE_CYCLES) ? WAIT_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GO,
        S_CHECK,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state, state_n;
    logic [3:0]         idx, idx_n;
    logic [3:0]         retry, retry_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               seen_low, seen_low_n;
    logic               nack_flag, nack_flag_n;
    logic               restart;

    logic               mgo_n;
    logic [3:0]         mstep_n;
    logic [23:0]        i2c_data_n;
    logic               busy_n;
    logic               done_n;
    logic               error_n;
    logic [7:0]         nack_total_n;

    // {reg[6:0], data[8:0]} for each table index.
    function automatic logic [15:0] table_entry(input logic [3:0] i);
        logic [15:0] e;
        case (i)
            4'd0:    e = {7'd15, 9'h000};
            4'd1:    e = {7'd0,  9'h017};
            4'd2:    e = {7'd1,  9'h017};
            4'd3:    e = {7'd2,  9'h079};
            4'd4:    e = {7'd3,  9'h079};
            4'd5:    e = {7'd4,  9'h012};
            4'd6:    e = {7'd5,  9'h000};
            4'd7:    e = {7'd6,  9'h000};
            4'd8:    e = {7'd7,  9'h042};
            4'd9:    e = {7'd8,  9'h000};
            4'd10:   e = {7'd9,  9'h001};
            default: e = 16'h0000;
        endcase
        return e;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_n      = state;
        idx_n        = idx;
        retry_n      = retry;
        seen_low_n   = seen_low;
        nack_flag_n  = nack_flag;
        nack_total_n = nack_total;
        i2c_data_n   = i2c_data;
        restart      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start || (AUTO_START != 0)) restart = 1'b1;
            end

            S_LOAD: begin
                if (cnt == CNT_W'(1)) begin
                    state_n    = S_GO;
                    seen_low_n = 1'b0;
                end
            end

            S_GO: begin
                // A stale mend=1 at GO entry is ignored: completion needs a
                // registered low sample first.
                if (seen_low && mend) begin
                    state_n     = S_CHECK;
                    nack_flag_n = mack;
                end else if (cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
                    state_n     = S_CHECK;
                    nack_flag_n = 1'b1;
                end else if (!mend) begin
                    seen_low_n  = 1'b1;
                end
            end

            S_CHECK: begin
                if (!nack_flag) begin
                    retry_n = 4'd0;
                    if (idx == LAST_IDX) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n   = idx + 4'd1;
                        state_n = S_SETTLE;
                    end
                end else begin
                    retry_n = retry + 4'd1;
                    if (nack_total != 8'hFF) nack_total_n = nack_total + 8'd1;
                    if (retry + 4'd1 == 4'(RETRY_MAX)) state_n = S_ERROR;
                    else                               state_n = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_n = S_LOAD;
            end

            S_DONE, S_ERROR: begin
                if (start) restart = 1'b1;
            end

            default: state_n = S_IDLE;
        endcase

        if (restart) begin
            state_n      = S_LOAD;
            idx_n        = 4'd0;
            retry_n      = 4'd0;
            nack_total_n = 8'd0;
        end

        // Shared phase counter: restarts on every state change, counts only
        // in the states that time themselves.
        if (state_n != state) begin
            cnt_n = '0;
        end else if (state == S_LOAD || state == S_GO || state == S_SETTLE) begin
            cnt_n = cnt + CNT_W'(1);
        end else begin
            cnt_n = cnt;
        end

        // Outputs are derived from the next state so that, once registered,
        // they describe the state the machine is actually in.
        mgo_n   = (state_n == S_GO);
        busy_n  = (state_n == S_LOAD) || (state_n == S_GO) ||
                  (state_n == S_CHECK) || (state_n == S_SETTLE);
        done_n  = (state_n == S_DONE);
        error_n = (state_n == S_ERROR);
        mstep_n = idx_n;
        if (state_n == S_LOAD) i2c_data_n = {DEV_ADDR, table_entry(idx_n)};
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= 4'd0;
            retry      <= 4'd0;
            cnt        <= '0;
            seen_low   <= 1'b0;
            nack_flag  <= 1'b0;
            mgo        <= 1'b0;
            mstep      <= 4'd0;
            i2c_data   <= 24'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            nack_total <= 8'd0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            retry      <= retry_n;
            cnt        <= cnt_n;
            seen_low   <= seen_low_n;
            nack_flag  <= nack_flag_n;
            mgo        <= mgo_n;
            mstep      <= mstep_n;
            i2c_data   <= i2c_data_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
            nack_total <= nack_total_n;
        end
    end

endmodule

// File: tb/tb_audio_codec_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_audio_codec_cfg_sequencer
//
// Scoreboard bench. A reference model turns a scenario description (which
// index misbehaves, how many times, and how) into the list of transfers the
// sequencer must issue and the final status it must report. The model pushes
// expected transfers into exp_q and programmer responses into rsp_q; a
// programmer model answers each transfer, and a monitor pops exp_q every time
// mgo rises and compares the presented word.
// A second instance with AUTO_START=0 covers the wait-for-start behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_audio_codec_cfg_sequencer;

    localparam int RETRY_MAX    = 3;
    localparam int WAIT_TIMEOUT = 255;

    localparam int M_ACK     = 0;
    localparam int M_NACK    = 1;
    localparam int M_TIMEOUT = 2;   // mend falls and never rises
    localparam int M_STALE   = 3;   // mend stays at its old 1 for the whole GO

    typedef struct {
        logic [23:0] word;
        int          idx;
        int          mode;
    } xfer_t;

    // Expected words straight from the register table.
    logic [23:0] words [11] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479,
                                24'h340679, 24'h340812, 24'h340A00, 24'h340C00,
                                24'h340E42, 24'h341000, 24'h341201};

    logic        clk, reset, start, mend, mack;
    logic        mgo, busy, done, error;
    logic [3:0]  mstep;
    logic [23:0] i2c_data;
    logic [7:0]  nack_total;

    logic        start2, mend2, mack2;
    logic        mgo2, busy2, done2, error2;
    logic [3:0]  mstep2;
    logic [23:0] i2c_data2;
    logic [7:0]  nack_total2;

    xfer_t       exp_q[$];
    int          rsp_q[$];
    logic        exp_done, exp_err;
    int          exp_mstep, exp_nack;
    logic [23:0] exp_last;

    int n_checks = 0;
    int n_errors = 0;

    audio_codec_cfg_sequencer #(
        .DEV_ADDR(8'h34), .RETRY_MAX(RETRY_MAX), .SETTLE_CYCLES(4),
        .WAIT_TIMEOUT(WAIT_TIMEOUT), .AUTO_START(1)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .mend(mend), .mack(mack),
        .mgo(mgo), .mstep(mstep), .i2c_data(i2c_data), .busy(busy),
        .done(done), .error(error), .nack_total(nack_total)
    );

    audio_codec_cfg_sequencer #(
        .DEV_ADDR(8'h34), .RETRY_MAX(RETRY_MAX), .SETTLE_CYCLES(4),
        .WAIT_TIMEOUT(WAIT_TIMEOUT), .AUTO_START(0)
    ) u_dut_manual (
        .clk(clk), .reset(reset), .start(start2), .mend(mend2), .mack(mack2),
        .mgo(mgo2), .mstep(mstep2), .i2c_data(i2c_data2), .busy(busy2),
        .done(done2), .error(error2), .nack_total(nack_total2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: derive transfer list and final status from the rules.
    task automatic plan(input int bad_idx, input int bad_cnt, input int bad_mode);
        int nacks;
        int attempt;
        int mode;
        xfer_t e;
        exp_q.delete();
        rsp_q.delete();
        nacks    = 0;
        exp_err  = 1'b0;
        exp_mstep = 10;
        for (int i = 0; i <= 10 && !exp_err; i++) begin
            attempt = 0;
            forever begin
                mode   = (i == bad_idx && attempt < bad_cnt) ? bad_mode : M_ACK;
                e.word = words[i];
                e.idx  = i;
                e.mode = mode;
                exp_q.push_back(e);
                rsp_q.push_back(mode);
                if (mode == M_ACK) break;
                nacks++;
                attempt++;
                if (attempt == RETRY_MAX) begin
                    exp_err   = 1'b1;
                    exp_mstep = i;
                    break;
                end
            end
        end
        exp_done = !exp_err;
        exp_nack = (nacks > 255) ? 255 : nacks;
        exp_last = words[exp_mstep];
    endtask

    task automatic wait_finish();
        int n = 0;
        while (!(done || error) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("run_finished", 32'(done || error), 32'd1);
    endtask

    task automatic end_checks(input string tag);
        @(negedge clk);
        check({tag, "_done"},       32'(done),       32'(exp_done));
        check({tag, "_error"},      32'(error),      32'(exp_err));
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_mstep"},      32'(mstep),      32'(exp_mstep));
        check({tag, "_nack_total"}, 32'(nack_total), 32'(exp_nack));
        check({tag, "_last_word"},  32'(i2c_data),   32'(exp_last));
        check({tag, "_all_sent"},   32'(exp_q.size()), 32'd0);
        repeat (10) @(negedge clk);
        check({tag, "_mgo_idle"},   32'(mgo),        32'd0);
        check({tag, "_excl"},       32'(done && error), 32'd0);
    endtask

    task automatic do_start(input string tag);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_load_busy"},  32'(busy),       32'd1);
        check({tag, "_load_done"},  32'(done),       32'd0);
        check({tag, "_load_error"}, 32'(error),      32'd0);
        check({tag, "_load_mstep"}, 32'(mstep),      32'd0);
        check({tag, "_load_word"},  32'(i2c_data),   32'h341E00);
        check({tag, "_load_nack"},  32'(nack_total), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mgo"},        32'(mgo),        32'd0);
        check({tag, "_mstep"},      32'(mstep),      32'd0);
        check({tag, "_i2c_data"},   32'(i2c_data),   32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_nack_total"}, 32'(nack_total), 32'd0);
    endtask

    // Programmer model: answers each mgo pulse with the planned response.
    initial begin
        int mode;
        mend = 1'b1;
        mack = 1'b0;
        forever begin
            @(negedge clk);
            if (mgo) begin
                mode = (rsp_q.size() != 0) ? rsp_q.pop_front() : M_ACK;
                if (mode == M_ACK || mode == M_NACK) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    mend = 1'b0;
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    mack = (mode == M_NACK);
                    mend = 1'b1;
                end else if (mode == M_TIMEOUT) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    mend = 1'b0;
                end else begin
                    mack = 1'b0;
                end
                for (int i = 0; i < 600 && mgo; i++) @(negedge clk);
                check("slave_mgo_release", 32'(mgo), 32'd0);
                mend = 1'b1;
            end
        end
    end

    // Monitor: every rising mgo is one transfer to compare against exp_q.
    initial begin
        xfer_t e;
        int    hi = 0;
        int    lo = 1000;
        int    cur_mode = M_ACK;
        logic  prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mgo && !prev) begin
                check("mgo_rearm_gap", 32'(lo >= 2), 32'd1);
                check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("xfer_word", 32'(i2c_data), 32'(e.word));
                    check("xfer_idx",  32'(mstep),    32'(e.idx));
                    cur_mode = e.mode;
                end else begin
                    cur_mode = M_ACK;
                end
                hi = 0;
            end
            if (!mgo && prev) begin
                if (cur_mode == M_TIMEOUT || cur_mode == M_STALE)
                    check("timeout_len", 32'(hi >= WAIT_TIMEOUT - 1 && hi <= WAIT_TIMEOUT + 1), 32'd1);
                lo = 0;
            end
            if (mgo) hi++;
            else     lo++;
            prev = mgo;
        end
    end

    initial begin
        int bi, bc, bm;
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        mend2  = 1'b1;
        mack2  = 1'b0;

        // Scenario 1: auto start, every word acknowledged.
        plan(-1, 0, M_ACK);
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(negedge clk) reset = 1'b0;

        // Manual-start instance stays idle until it sees start.
        repeat (20) @(negedge clk);
        check("manual_idle_busy", 32'(busy2),     32'd0);
        check("manual_idle_mgo",  32'(mgo2),      32'd0);
        check("manual_idle_word", 32'(i2c_data2), 32'd0);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        check("manual_start_busy",  32'(busy2),     32'd1);
        check("manual_start_word",  32'(i2c_data2), 32'h341E00);
        check("manual_start_mstep", 32'(mstep2),    32'd0);
        repeat (2) @(negedge clk);
        check("manual_start_mgo",   32'(mgo2),      32'd1);

        wait_finish();
        end_checks("all_ack");

        // Scenario 2: first attempt at idx 4 NACKed, restart from DONE.
        plan(4, 1, M_NACK);
        do_start("one_nack");
        wait_finish();
        end_checks("one_nack");

        // Scenario 3: idx 5 NACKed on every attempt -> ERROR.
        plan(5, RETRY_MAX, M_NACK);
        do_start("retry_exhaust");
        wait_finish();
        end_checks("retry_exhaust");

        // Scenario 4: restart from ERROR, timeout at idx 2, start pulsed mid-run.
        plan(2, 1, M_TIMEOUT);
        do_start("timeout");
        repeat (40) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_finish();
        end_checks("timeout");

        // Scenario 5: mend stuck high from the previous transfer at idx 7.
        plan(7, 1, M_STALE);
        do_start("stale_mend");
        wait_finish();
        end_checks("stale_mend");

        // Randomized scenarios.
        for (int k = 0; k < 4; k++) begin
            bi = $urandom_range(0, 10);
            bc = $urandom_range(0, RETRY_MAX);
            bm = 1 + $urandom_range(0, 2);
            plan(bi, bc, bm);
            do_start("rand");
            wait_finish();
            end_checks("rand");
        end

        // Scenario 6: asynchronous reset while GO at idx 4, then auto restart.
        plan(-1, 0, M_ACK);
        do_start("rst_mid");
        for (int i = 0; i < 3000 && !(mgo && mstep == 4'd4); i++) @(negedge clk);
        check("rst_mid_reached_go4", 32'(mgo && mstep == 4'd4), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        repeat (20) @(negedge clk);
        plan(-1, 0, M_ACK);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("rst_mid_restart_busy",  32'(busy),     32'd1);
        check("rst_mid_restart_mstep", 32'(mstep),    32'd0);
        check("rst_mid_restart_word",  32'(i2c_data), 32'h341E00);
        wait_finish();
        end_checks("rst_mid_rerun");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_codec_cfg_sequencer.md
Name: audio_codec_cfg_sequencer

Overview:
- Upstream feeder for the I2C serial programmer.
- Walks a fixed 11-entry WM8731 codec register table and presents one 24-bit word per transaction as {device address, 7-bit register, 9-bit data}.
- Handshakes each transfer via mgo/mend, checks mack, and retries NACKed words.
- Runs on the 40 kHz I2C control clock shared with the programmer; reports busy/done/error to the top level.

Parameters:
- DEV_ADDR, 8'h34, I2C write address placed in i2c_data[23:16].
- RETRY_MAX, 3, failed attempts per word before ERROR (range 1..15).
- SETTLE_CYCLES, 4, mgo-low idle cycles between transfers (≥2).
- WAIT_TIMEOUT, 255, GO-state cycles without mend completion before the transfer counts as NACK.
- AUTO_START, 1, 1 = begin sequence on the first cycle after reset release without a start pulse.

Ports:
- clk  in  1  I2C control clock, same clock as the programmer.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle request to (re)run the sequence.
- mend  in  1  programmer transfer-end flag: 0 = armed/in progress, 1 = finished.
- mack  in  1  programmer ack flag: 1 = NACK seen on any byte; valid while mend=1.
- mgo  out  1  transfer enable to programmer.
- mstep  out  4  current table index.
- i2c_data  out  24  word to transmit.
- busy  out  1  sequence in progress.
- done  out  1  all words acknowledged.
- error  out  1  a word exhausted its retries.
- nack_total  out  8  saturating count of failed attempts in the current run.

Behaviour:
- Table, index: reg, data → word:
  0: R15, 000 → 341E00; 1: R0, 017 → 340017; 2: R1, 017 → 340217; 3: R2, 079 → 340479; 4: R3, 079 → 340679; 5: R4, 012 → 340812; 6: R5, 000 → 340A00; 7: R6, 000 → 340C00; 8: R7, 042 → 340E42; 9: R8, 000 → 341000; 10: R9, 001 → 341201.
- Word packing: i2c_data = {DEV_ADDR, reg[6:0], data[8:0]}. Entries are shown with DEV_ADDR=34; the upper byte follows DEV_ADDR.
- Reset (asynchronous, any state): state=IDLE, idx=0, retry=0, mgo=0, mstep=0, i2c_data=0, busy=0, done=0, error=0, nack_total=0.
- States and transitions:
  - IDLE: mgo=0, busy=0. Go to LOAD on start=1, or on the first clock after reset release if AUTO_START=1. On entry to LOAD: idx=0, retry=0, nack_total=0, done=0, error=0.
  - LOAD (2 cycles): mgo=0, i2c_data=table[idx], mstep=idx, busy=1. Then GO.
  - GO: mgo=1. i2c_data is held constant from LOAD through CHECK. A seen_low flag sets when mend=0 is sampled. Exit to CHECK when seen_low=1 and mend=1. Exit to CHECK as a forced NACK when the timeout counter reaches WAIT_TIMEOUT; the counter clears on GO entry.
  - CHECK (1 cycle): mgo=0.
    - ACK (mack=0, no timeout): retry=0. If idx=10, go to DONE; otherwise idx+1, go to SETTLE.
    - NACK: retry+1 and nack_total+1 (saturating at 255). If the new retry equals RETRY_MAX, go to ERROR (idx is held); otherwise go to SETTLE with the same idx.
  - SETTLE: mgo=0 for SETTLE_CYCLES cycles, then LOAD.
  - DONE: done=1, busy=0, mgo=0, mstep=10, i2c_data holds the last word.
  - ERROR: error=1, busy=0, mgo=0, mstep=failing idx.
  - From DONE or ERROR, start=1 restarts at LOAD with the same clears as from IDLE.
- start is ignored while busy=1.
- done and error are never 1 together.
- mgo never rises within 2 cycles of its previous fall, so the programmer counter re-arms.
- mend=1 while in LOAD or SETTLE is don't-care.
- Only the seen_low-then-high sequence in GO completes a transfer. A stale mend=1 at GO entry must not complete it.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- AUTO_START=1, slave model always ACKs → 11 transfers in order, first i2c_data=24'h341E00, last 24'h341201; then done=1, busy=0, mgo=0, mstep=10, nack_total=0.
- NACK only the first attempt of idx 4 → 24'h340679 is sent twice, sequence completes, done=1, nack_total=1.
- RETRY_MAX=3, NACK every attempt at idx 5 → exactly 3 transfers of 24'h340812, then error=1, done=0, mstep=5, nack_total=3, mgo stays 0.
- mend held at 0 in GO → CHECK after 255 cycles treated as NACK, retry increments, same word re-sent after SETTLE; mend=1 held already at GO entry does not count as completion.
- Assert reset during the GO state at idx 4 → all outputs are at reset values in the same cycle; after release with AUTO_START=1, restart at idx 0 with 24'h341E00.
- AUTO_START=0: no activity until start. start pulsed mid-sequence → ignored. start in DONE → full rerun with done cleared on LOAD entry. start in ERROR → error cleared, idx=0.
